// File: rtl/rotator_pipe.sv
// rotator_pipe: pipelined complex twiddle rotator for the serial FFT datapath.
// Accepts interleaved (re, im) word pairs, multiplies each pair by W = cos - j*sin
// and emits the rotated (re', im') pair as an interleaved stream, PIPE+2 cycles
// after the re word. Results are rounded half up.
// Build option: define ROT_SAT_EN to clamp out-of-range results and raise ovf;
// when it is undefined, results wrap to DW bits and ovf stays 0.
module rotator_pipe #(
    parameter int unsigned DW   = 16,
    parameter int unsigned TW   = 8,
    parameter int unsigned PIPE = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic [TW-1:0] tw_cos,
    input  logic [TW-1:0] tw_sin,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_im,
    output logic          err_proto,
    output logic          ovf
);

`ifdef ROT_SAT_EN
    localparam bit SatEn = 1'b1;
`else
    localparam bit SatEn = 1'b0;
`endif

    // product, sum and post-shift widths
    localparam int unsigned PW = DW + TW;
    localparam int unsigned SW = PW + 1;
    localparam int unsigned RW = DW + 2;

    // half an output LSB, added before the shift for round-half-up
    localparam logic signed [SW-1:0] RndC = SW'(64'd1 << (TW - 2));

    typedef enum logic {
        PH_RE = 1'b0,
        PH_IM = 1'b1
    } phase_t;

    // ------------------------------------------------------------------
    // Input framing
    // ------------------------------------------------------------------
    phase_t phase_q, phase_d;
    logic   cap_re;
    logic   pair_ok;
    logic   drop;

    logic signed [DW-1:0] re_q;
    logic signed [TW-1:0] cos_q;
    logic signed [TW-1:0] sin_q;
    logic signed [DW-1:0] im_w;

    assign im_w = in_data;

    // phase state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PH_RE;
        end else begin
            phase_q <= phase_d;
        end
    end

    // phase next-state: re word opens a pair, the very next cycle must close it
    always_comb begin
        phase_d = phase_q;
        cap_re  = 1'b0;
        pair_ok = 1'b0;
        drop    = 1'b0;
        if (clr) begin
            phase_d = PH_RE;
        end else begin
            case (phase_q)
                PH_RE: begin
                    if (in_valid) begin
                        cap_re  = 1'b1;
                        phase_d = PH_IM;
                    end
                end
                PH_IM: begin
                    phase_d = PH_RE;
                    if (in_valid) begin
                        pair_ok = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end
                default: phase_d = PH_RE;
            endcase
        end
    end

    // hold the re word and its twiddle until the im word arrives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            re_q  <= '0;
            cos_q <= '0;
            sin_q <= '0;
        end else if (cap_re) begin
            re_q  <= in_data;
            cos_q <= tw_cos;
            sin_q <= tw_sin;
        end
    end

    // ------------------------------------------------------------------
    // Multiplier pipeline
    // ------------------------------------------------------------------
    logic signed [PW-1:0] p_rc_w, p_is_w, p_ic_w, p_rs_w;

    assign p_rc_w = PW'(re_q) * PW'(cos_q);
    assign p_is_w = PW'(im_w) * PW'(sin_q);
    assign p_ic_w = PW'(im_w) * PW'(cos_q);
    assign p_rs_w = PW'(re_q) * PW'(sin_q);

    logic [PIPE-1:0]      pv_q;
    logic signed [PW-1:0] prc_q [PIPE];
    logic signed [PW-1:0] pis_q [PIPE];
    logic signed [PW-1:0] pic_q [PIPE];
    logic signed [PW-1:0] prs_q [PIPE];

    // products enter on the im cycle, then ripple down PIPE stages with their valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv_q <= '0;
            for (int unsigned i = 0; i < PIPE; i++) begin
                prc_q[i] <= '0;
                pis_q[i] <= '0;
                pic_q[i] <= '0;
                prs_q[i] <= '0;
            end
        end else begin
            pv_q[0] <= pair_ok;
            if (pair_ok) begin
                prc_q[0] <= p_rc_w;
                pis_q[0] <= p_is_w;
                pic_q[0] <= p_ic_w;
                prs_q[0] <= p_rs_w;
            end
            for (int unsigned i = 1; i < PIPE; i++) begin
                pv_q[i]  <= clr ? 1'b0 : pv_q[i-1];
                prc_q[i] <= prc_q[i-1];
                pis_q[i] <= pis_q[i-1];
                pic_q[i] <= pic_q[i-1];
                prs_q[i] <= prs_q[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Sum, round and reduce
    // ------------------------------------------------------------------
    logic signed [SW-1:0] re_sum_w, im_sum_w;
    logic signed [RW-1:0] re_sh_w, im_sh_w;
    logic [DW:0]          re_red_w, im_red_w;

    assign re_sum_w = SW'(prc_q[PIPE-1]) + SW'(pis_q[PIPE-1]) + RndC;
    assign im_sum_w = SW'(pic_q[PIPE-1]) - SW'(prs_q[PIPE-1]) + RndC;
    assign re_sh_w  = RW'(re_sum_w >>> (TW - 1));
    assign im_sh_w  = RW'(im_sum_w >>> (TW - 1));

    // returns {clipped, word}: clamp when saturation is built in, otherwise wrap
    function automatic logic [DW:0] reduce_word(input logic signed [RW-1:0] v);
        logic       in_range;
        logic [DW:0] r;
        in_range = (v[RW-1] == v[DW]) && (v[DW] == v[DW-1]);
        r = {1'b0, v[DW-1:0]};
        if (SatEn && !in_range) begin
            r = v[RW-1] ? {1'b1, 1'b1, {(DW-1){1'b0}}}
                        : {1'b1, 1'b0, {(DW-1){1'b1}}};
        end
        return r;
    endfunction

    assign re_red_w = reduce_word(re_sh_w);
    assign im_red_w = reduce_word(im_sh_w);

    // ------------------------------------------------------------------
    // Output serialiser and sticky flags
    // ------------------------------------------------------------------
    logic          out_valid_q, out_valid_d;
    logic          out_im_q, out_im_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic [DW-1:0] im_hold_q, im_hold_d;
    logic          im_clip_q, im_clip_d;
    logic          pend_q, pend_d;
    logic          err_q, err_d;
    logic          ovf_q, ovf_d;

    // re' goes out first while im' waits one cycle in im_hold; pairs are never
    // closer than two cycles, so a pending im' cannot collide with a new re'
    always_comb begin
        out_valid_d = 1'b0;
        out_im_d    = 1'b0;
        out_data_d  = out_data_q;
        im_hold_d   = im_hold_q;
        im_clip_d   = im_clip_q;
        pend_d      = 1'b0;
        err_d       = err_q | drop;
        ovf_d       = ovf_q;
        if (clr) begin
            out_data_d = '0;
            im_hold_d  = '0;
            im_clip_d  = 1'b0;
            err_d      = 1'b0;
            ovf_d      = 1'b0;
        end else if (pv_q[PIPE-1]) begin
            out_valid_d = 1'b1;
            out_data_d  = re_red_w[DW-1:0];
            im_hold_d   = im_red_w[DW-1:0];
            im_clip_d   = im_red_w[DW];
            pend_d      = 1'b1;
            ovf_d       = ovf_q | re_red_w[DW];
        end else if (pend_q) begin
            out_valid_d = 1'b1;
            out_im_d    = 1'b1;
            out_data_d  = im_hold_q;
            ovf_d       = ovf_q | im_clip_q;
        end
    end

    // output and flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_im_q    <= 1'b0;
            out_data_q  <= '0;
            im_hold_q   <= '0;
            im_clip_q   <= 1'b0;
            pend_q      <= 1'b0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_im_q    <= out_im_d;
            out_data_q  <= out_data_d;
            im_hold_q   <= im_hold_d;
            im_clip_q   <= im_clip_d;
            pend_q      <= pend_d;
            err_q       <= err_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_im    = out_im_q;
    assign out_data  = out_data_q;
    assign err_proto = err_q;
    assign ovf       = ovf_q;

endmodule
